// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS datapath: PC-source and ALUOp encodings,
// the word width, and the jump-target helper.
package mc_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JMP  = 2'b10;
  localparam logic [1:0] PCSRC_HOLD = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_BNE   = 2'b11;

  // J-type target: the upper PC nibble is kept and the 26-bit field becomes a word index.
  function automatic logic [WORD_W-1:0] jump_target(input logic [WORD_W-1:0] cur_pc,
                                                    input logic [WORD_W-1:0] cur_ir);
    return {cur_pc[31:28], cur_ir[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/mc_pc_unit.sv
// Program counter with branch decision, next-PC select and a sticky flag that
// records any rejected (misaligned) PC write.
module mc_pc_unit
  import mc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic [1:0]        pc_source,
  input  logic [1:0]        alu_op,
  input  logic              alu_zero,
  input  logic [WORD_W-1:0] alu_result,
  input  logic [WORD_W-1:0] alu_out,
  input  logic [WORD_W-1:0] ir,
  output logic [WORD_W-1:0] pc,
  output logic              pc_misalign
);

  logic              branch_taken;
  logic              pc_en;
  logic              pc_update;
  logic [WORD_W-1:0] next_pc;

  always_comb begin
    branch_taken = (alu_op == ALUOP_BNE) ? !alu_zero : alu_zero;
    pc_en        = pc_write | (pc_write_cond & branch_taken);
    next_pc      = pc;
    case (pc_source)
      PCSRC_SEQ:  next_pc = alu_result;
      PCSRC_BR:   next_pc = alu_out;
      PCSRC_JMP:  next_pc = jump_target(pc, ir);
      default:    next_pc = pc;
    endcase
    // Hold select suppresses both the write and the alignment check.
    pc_update = pc_en && (pc_source != PCSRC_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC;
      pc_misalign <= 1'b0;
    end else if (pc_update) begin
      if (next_pc[1:0] != 2'b00) begin
        pc_misalign <= 1'b1;
      end else begin
        pc <= next_pc;
      end
    end
  end

endmodule

// File: rtl/mc_datapath_regs.sv
// Inter-cycle register bank of the multicycle MIPS core: IR, MDR, A, B, ALUOut,
// the retired-fetch counter, the memory address mux and the PC unit.
module mc_datapath_regs
  import mc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic [1:0]        pc_source,
  input  logic [1:0]        alu_op,
  input  logic              ir_write,
  input  logic              lord,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic [WORD_W-1:0] rf_rdata1,
  input  logic [WORD_W-1:0] rf_rdata2,
  input  logic [WORD_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] ir,
  output logic [WORD_W-1:0] mdr,
  output logic [WORD_W-1:0] reg_a,
  output logic [WORD_W-1:0] reg_b,
  output logic [WORD_W-1:0] alu_out,
  output logic [WORD_W-1:0] mem_addr,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic              pc_misalign
);

  mc_pc_unit #(
    .RESET_PC(RESET_PC)
  ) u_pc_unit (
    .clk          (clk),
    .rst          (rst),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_source    (pc_source),
    .alu_op       (alu_op),
    .alu_zero     (alu_zero),
    .alu_result   (alu_result),
    .alu_out      (alu_out),
    .ir           (ir),
    .pc           (pc),
    .pc_misalign  (pc_misalign)
  );

  // Latches between microcycles load every cycle; only IR and the counter are gated.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ir        <= '0;
      mdr       <= '0;
      reg_a     <= '0;
      reg_b     <= '0;
      alu_out   <= '0;
      fetch_cnt <= '0;
    end else begin
      mdr     <= mem_rdata;
      reg_a   <= rf_rdata1;
      reg_b   <= rf_rdata2;
      alu_out <= alu_result;
      if (ir_write) begin
        ir        <= mem_rdata;
        fetch_cnt <= fetch_cnt + 1'b1;
      end
    end
  end

  assign mem_addr = lord ? alu_out : pc;

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Directed self-checking bench for mc_datapath_regs, built with a 4-bit fetch
// counter so the wrap-around can be reached quickly.
module tb_mc_datapath_regs;

  logic        clk;
  logic        rst;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  pc_source;
  logic [1:0]  alu_op;
  logic        ir_write;
  logic        lord;
  logic [31:0] mem_rdata;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic [31:0] reg_a;
  logic [31:0] reg_b;
  logic [31:0] alu_out;
  logic [31:0] mem_addr;
  logic [3:0]  fetch_cnt;
  logic        pc_misalign;

  int checks = 0;
  int errors = 0;

  mc_datapath_regs #(
    .RESET_PC(32'h0000_0000),
    .CNT_W   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_source    (pc_source),
    .alu_op       (alu_op),
    .ir_write     (ir_write),
    .lord         (lord),
    .mem_rdata    (mem_rdata),
    .rf_rdata1    (rf_rdata1),
    .rf_rdata2    (rf_rdata2),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .pc           (pc),
    .ir           (ir),
    .mdr          (mdr),
    .reg_a        (reg_a),
    .reg_b        (reg_b),
    .alu_out      (alu_out),
    .mem_addr     (mem_addr),
    .fetch_cnt    (fetch_cnt),
    .pc_misalign  (pc_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one microcycle's controls, then advance past the next rising edge.
  task automatic applyStimulus(input logic pw, input logic pwc, input logic [1:0] ps,
                               input logic [1:0] aop, input logic iw,
                               input logic [31:0] mrd, input logic [31:0] ares,
                               input logic az);
    pc_write      = pw;
    pc_write_cond = pwc;
    pc_source     = ps;
    alu_op        = aop;
    ir_write      = iw;
    mem_rdata     = mrd;
    alu_result    = ares;
    alu_zero      = az;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    lord = 1'b0;
    rf_rdata1 = '0;
    rf_rdata2 = '0;

    // Reset held for two edges with random inputs.
    for (int i = 0; i < 2; i++) begin
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      lord = 1'($urandom);
      applyStimulus(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                    1'($urandom), $urandom, $urandom, 1'($urandom));
    end
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_ir", ir, 32'h0);
    checkOutput("rst_mdr", mdr, 32'h0);
    checkOutput("rst_alu_out", alu_out, 32'h0);
    checkOutput("rst_fetch_cnt", {28'h0, fetch_cnt}, 32'h0);
    checkOutput("rst_misalign", {31'h0, pc_misalign}, 32'h0);

    // Release: nothing moves until the following edge.
    rst = 1'b1;
    lord = 1'b0;
    rf_rdata1 = 32'hAAAA_0001;
    rf_rdata2 = 32'h5555_0002;
    pc_write = 1'b0; pc_write_cond = 1'b0; pc_source = 2'b00; alu_op = 2'b00;
    ir_write = 1'b0; mem_rdata = 32'h1234_5678; alu_result = 32'h0000_0010; alu_zero = 1'b0;
    #1;
    checkOutput("release_mdr_same_cycle", mdr, 32'h0);
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h1234_5678, 32'h0000_0010, 1'b0);
    checkOutput("release_mdr", mdr, 32'h1234_5678);
    checkOutput("release_reg_a", reg_a, 32'hAAAA_0001);
    checkOutput("release_reg_b", reg_b, 32'h5555_0002);
    checkOutput("release_alu_out", alu_out, 32'h0000_0010);
    checkOutput("release_ir_hold", ir, 32'h0);

    // Fetch.
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 32'h8C22_0004, 32'h0000_0004, 1'b0);
    checkOutput("fetch_ir", ir, 32'h8C22_0004);
    checkOutput("fetch_pc", pc, 32'h0000_0004);
    checkOutput("fetch_cnt1", {28'h0, fetch_cnt}, 32'h1);

    // Branches: beq taken, then retarget to 0x80 for not-taken / bne cases.
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0000_0040, 1'b0);
    checkOutput("br_alu_out", alu_out, 32'h0000_0040);
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 32'h0, 32'h0000_0040, 1'b1);
    checkOutput("beq_taken_pc", pc, 32'h0000_0040);
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0000_0080, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 32'h0, 32'h0000_0080, 1'b0);
    checkOutput("beq_not_taken_pc", pc, 32'h0000_0040);
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b11, 1'b0, 32'h0, 32'h0000_0080, 1'b1);
    checkOutput("bne_not_taken_pc", pc, 32'h0000_0040);
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b11, 1'b0, 32'h0, 32'h0000_0080, 1'b0);
    checkOutput("bne_taken_pc", pc, 32'h0000_0080);

    // Jump: set pc and ir, then jump; repeat with an IR load on the same edge.
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 32'h0800_0100, 32'h1000_0010, 1'b0);
    checkOutput("jmp_setup_pc", pc, 32'h1000_0010);
    checkOutput("jmp_setup_ir", ir, 32'h0800_0100);
    applyStimulus(1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 32'h0, 32'h1000_0010, 1'b0);
    checkOutput("jmp_pc", pc, 32'h1000_0400);
    applyStimulus(1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 32'h0800_0200, 32'h1000_0010, 1'b0);
    checkOutput("jmp_old_ir_pc", pc, 32'h1000_0400);
    checkOutput("jmp_new_ir", ir, 32'h0800_0200);
    checkOutput("jmp_fetch_cnt", {28'h0, fetch_cnt}, 32'h3);

    // Address mux, then a rejected misaligned write.
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0000_0024, 1'b0);
    lord = 1'b1;
    #1;
    checkOutput("mem_addr_aluout", mem_addr, 32'h0000_0024);
    lord = 1'b0;
    #1;
    checkOutput("mem_addr_pc", mem_addr, 32'h1000_0400);
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0000_0006, 1'b0);
    checkOutput("misalign_pc_hold", pc, 32'h1000_0400);
    checkOutput("misalign_set", {31'h0, pc_misalign}, 32'h1);
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0000_0008, 1'b0);
    checkOutput("aligned_after_misalign_pc", pc, 32'h0000_0008);
    checkOutput("misalign_sticky", {31'h0, pc_misalign}, 32'h1);
    applyStimulus(1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 32'h0, 32'h0000_000C, 1'b0);
    checkOutput("hold_src_pc", pc, 32'h0000_0008);

    // Reset in the middle of a branch/fetch cycle.
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b01, 1'b1, 32'hDEAD_BEEF, 32'h0000_0040, 1'b1);
    checkOutput("midrst_pc", pc, 32'h0);
    checkOutput("midrst_ir", ir, 32'h0);
    checkOutput("midrst_alu_out", alu_out, 32'h0);
    checkOutput("midrst_fetch_cnt", {28'h0, fetch_cnt}, 32'h0);
    checkOutput("midrst_misalign", {31'h0, pc_misalign}, 32'h0);
    rst = 1'b1;

    // Counter wrap on the 4-bit build.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 32'h0000_1000 + i, 32'h0, 1'b0);
    end
    checkOutput("fetch_cnt_max", {28'h0, fetch_cnt}, 32'hF);
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 32'h0000_2000, 32'h0, 1'b0);
    checkOutput("fetch_cnt_wrap", {28'h0, fetch_cnt}, 32'h0);
    checkOutput("fetch_wrap_ir", ir, 32'h0000_2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
